// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: check-bit count, code position <-> data index maps, syndrome class.
// Pure constants and functions; no logic, no latency, no flow control.
// Used at elaboration time to build check masks and correction decoders.
package ecc_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } syn_class_e;

    // Smallest H with 2^H >= data_w + H + 1.
    function automatic int calc_h(input int data_w);
        int h;
        h = 1;
        while ((1 << h) < data_w + h + 1) h = h + 1;
        return h;
    endfunction

    // Data index held at a code position, or -1 where a check bit sits (powers of two).
    function automatic int pos2idx(input int pos);
        if ((pos & (pos - 1)) == 0) return -1;
        return pos - $clog2(pos + 1) - 1;
    endfunction

    function automatic int idx2pos(input int idx);
        int pos;
        pos = 2;
        for (int k = 0; k <= idx; k++) begin
            pos = pos + 1;
            while ((pos & (pos - 1)) == 0) pos = pos + 1;
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_decode.sv
// SECDED decode of one word: syndrome/overall parity, single-bit correction, double-error flag.
// Latency: purely combinational.
// Backpressure: none; the caller's pipeline registers own flow control.
module secded_decode
    import ecc_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int H      = calc_h(DATA_W),
    localparam int PAR_W  = H + 1
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [PAR_W-1:0]  i_parity,
    output logic [DATA_W-1:0] o_data,
    output logic [PAR_W-1:0]  o_parity,
    output logic              o_sec,
    output logic              o_ded
);

    localparam int N = DATA_W + H;
    localparam logic [H-1:0] N_S = H'(N);

    typedef logic [H-1:0][DATA_W-1:0] mask_t;

    function automatic mask_t build_masks();
        mask_t m;
        int    d;
        m = '0;
        for (int p = 1; p <= N; p++) begin
            d = pos2idx(p);
            if (d >= 0) begin
                for (int i = 0; i < H; i++)
                    if (((p >> i) & 1) != 0) m[i][d] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam mask_t CHK_MASK = build_masks();

    logic [H-1:0]      w_calc;
    logic [H-1:0]      w_syn;
    logic [H-1:0]      w_cflip;
    logic [DATA_W-1:0] w_dflip;
    logic              w_op;
    syn_class_e        w_class;

    for (genvar gi = 0; gi < H; gi++) begin : g_chk
        assign w_calc[gi]  = ^(i_data & CHK_MASK[gi]);
        assign w_cflip[gi] = (w_syn == H'(1 << gi));
    end

    for (genvar gd = 0; gd < DATA_W; gd++) begin : g_dat
        assign w_dflip[gd] = (w_syn == H'(idx2pos(gd)));
    end

    assign w_syn = w_calc ^ i_parity[H-1:0];
    assign w_op  = ^{i_data, i_parity};

    always_comb begin
        w_class = CLEAN;
        if (w_op)
            w_class = (w_syn > N_S) ? DED : SEC;
        else if (w_syn != '0)
            w_class = DED;
    end

    assign o_sec = (w_class == SEC);
    assign o_ded = (w_class == DED);

    // Flips are gated by SEC, so a DED word leaves here untouched (raw).
    assign o_data   = o_sec ? (i_data ^ w_dflip) : i_data;
    assign o_parity = o_sec ? (i_parity ^ {w_syn == '0, w_cflip}) : i_parity;

endmodule

// File: rtl/ecc_load_pipe.sv
// Cache load path: SECDED correct/flag, scrub write-back of corrected words, saturating error counts.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: out_ready, or a full undrained scrub register facing a scrub word, stalls S2, then S1, then in_ready.
module ecc_load_pipe
    import ecc_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 32,
    parameter int  CNT_W  = 16,
    localparam int H      = calc_h(DATA_W),
    localparam int PAR_W  = H + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAR_W-1:0]  in_parity,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_special,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_parity,
    output logic              out_sec,
    output logic              out_ded,
    output logic              scrub_valid,
    input  logic              scrub_ready,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic [DATA_W-1:0] scrub_data,
    output logic [PAR_W-1:0]  scrub_parity,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    logic              r_s1_vld, r_s1_spec;
    logic [DATA_W-1:0] r_s1_data;
    logic [PAR_W-1:0]  r_s1_par;
    logic [ADDR_W-1:0] r_s1_addr;

    logic              r_s2_vld, r_s2_spec, r_s2_sec, r_s2_ded;
    logic [DATA_W-1:0] r_s2_data;
    logic [PAR_W-1:0]  r_s2_par;
    logic [ADDR_W-1:0] r_s2_addr;

    logic              r_scr_vld;
    logic [ADDR_W-1:0] r_scr_addr;
    logic [DATA_W-1:0] r_scr_data;
    logic [PAR_W-1:0]  r_scr_par;

    logic [CNT_W-1:0]  r_sec_cnt, r_ded_cnt;

    logic              w_s1_rdy, w_s2_rdy, w_scrub_block, w_out_fire, w_scrub_load;
    logic [DATA_W-1:0] w_cor_data;
    logic [PAR_W-1:0]  w_cor_par;
    logic              w_sec, w_ded;

    secded_decode #(.DATA_W(DATA_W)) u_dec (
        .i_data   (r_s1_data),
        .i_parity (r_s1_par),
        .o_data   (w_cor_data),
        .o_parity (w_cor_par),
        .o_sec    (w_sec),
        .o_ded    (w_ded)
    );

    assign w_scrub_block = r_s2_vld & r_s2_sec & ~r_s2_spec & r_scr_vld & ~scrub_ready;
    assign w_out_fire    = r_s2_vld & out_ready & ~w_scrub_block;
    assign w_s2_rdy      = ~r_s2_vld | (out_ready & ~w_scrub_block);
    assign w_s1_rdy      = ~r_s1_vld | w_s2_rdy;
    assign w_scrub_load  = w_out_fire & r_s2_sec & ~r_s2_spec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_spec <= 1'b0;
            r_s1_data <= '0;
            r_s1_par  <= '0;
            r_s1_addr <= '0;
        end else if (w_s1_rdy) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_spec <= in_special;
                r_s1_data <= in_data;
                r_s1_par  <= in_parity;
                r_s1_addr <= in_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_spec <= 1'b0;
            r_s2_sec  <= 1'b0;
            r_s2_ded  <= 1'b0;
            r_s2_data <= '0;
            r_s2_par  <= '0;
            r_s2_addr <= '0;
        end else if (w_s2_rdy) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_spec <= r_s1_spec;
                r_s2_sec  <= w_sec;
                r_s2_ded  <= w_ded;
                r_s2_data <= r_s1_spec ? r_s1_data : w_cor_data;
                r_s2_par  <= r_s1_spec ? r_s1_par  : w_cor_par;
                r_s2_addr <= r_s1_addr;
            end
        end
    end

    // A load here implies the old entry drains this cycle or was empty, so no bubble on reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scr_vld  <= 1'b0;
            r_scr_addr <= '0;
            r_scr_data <= '0;
            r_scr_par  <= '0;
        end else if (w_scrub_load) begin
            r_scr_vld  <= 1'b1;
            r_scr_addr <= r_s2_addr;
            r_scr_data <= r_s2_data;
            r_scr_par  <= r_s2_par;
        end else if (scrub_ready) begin
            r_scr_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (w_out_fire && r_s2_sec && r_sec_cnt != '1) r_sec_cnt <= r_sec_cnt + CNT_W'(1);
            if (w_out_fire && r_s2_ded && r_ded_cnt != '1) r_ded_cnt <= r_ded_cnt + CNT_W'(1);
        end
    end

    assign in_ready     = w_s1_rdy;
    assign out_valid    = r_s2_vld;
    assign out_data     = r_s2_data;
    assign out_parity   = r_s2_par;
    assign out_sec      = r_s2_sec;
    assign out_ded      = r_s2_ded;
    assign scrub_valid  = r_scr_vld;
    assign scrub_addr   = r_scr_addr;
    assign scrub_data   = r_scr_data;
    assign scrub_parity = r_scr_par;
    assign sec_cnt      = r_sec_cnt;
    assign ded_cnt      = r_ded_cnt;

endmodule

// File: tb/tb_ecc_load_pipe.sv
// Scoreboard bench for ecc_load_pipe: directed words with hand-computed results at DATA_W=32, CNT_W=3.
// Output and scrub monitors pop expected queues on each completed handshake.
module tb_ecc_load_pipe;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 3;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_special = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [PW-1:0] in_parity = '0;
    logic [AW-1:0] in_addr = '0;
    logic          out_valid, out_sec, out_ded;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_parity;
    logic          scrub_valid;
    logic          scrub_ready = 1'b0;
    logic [AW-1:0] scrub_addr;
    logic [DW-1:0] scrub_data;
    logic [PW-1:0] scrub_parity;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] sec_cnt, ded_cnt;

    always #5 clk = ~clk;

    ecc_load_pipe #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
        .in_addr(in_addr), .in_special(in_special),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_parity(out_parity),
        .out_sec(out_sec), .out_ded(out_ded),
        .scrub_valid(scrub_valid), .scrub_ready(scrub_ready), .scrub_addr(scrub_addr),
        .scrub_data(scrub_data), .scrub_parity(scrub_parity),
        .clr_cnt(clr_cnt), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        logic          sec;
        logic          ded;
        logic          spec;
    } out_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [PW-1:0] p;
    } scr_t;

    out_t exp_q[$];
    scr_t scr_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, before the handshake edge.
    initial begin
        out_t e;
        scr_t s;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {32'h0, out_data}, 64'hDEAD);
                end else if (!(exp_q[0].sec && !exp_q[0].spec && scrub_valid && !scrub_ready)) begin
                    e = exp_q.pop_front();
                    chk("out_data",   64'(out_data),   64'(e.d));
                    chk("out_parity", 64'(out_parity), 64'(e.p));
                    chk("out_sec",    64'(out_sec),    64'(e.sec));
                    chk("out_ded",    64'(out_ded),    64'(e.ded));
                end
            end
            if (rst_n && scrub_valid && scrub_ready) begin
                if (scr_q.size() == 0) begin
                    chk("unexpected_scrub", 64'(scrub_addr), 64'hDEAD);
                end else begin
                    s = scr_q.pop_front();
                    chk("scrub_addr",   64'(scrub_addr),   64'(s.a));
                    chk("scrub_data",   64'(scrub_data),   64'(s.d));
                    chk("scrub_parity", 64'(scrub_parity), 64'(s.p));
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic [AW-1:0] a,
                        input logic spec, input logic [DW-1:0] ed, input logic [PW-1:0] ep,
                        input logic es, input logic edd);
        int n;
        n = 0;
        in_data = d; in_parity = p; in_addr = a; in_special = spec; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_in_ready_timeout", 64'(in_ready), 64'h1);
            @(negedge clk);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{d: ed, p: ep, sec: es, ded: edd, spec: spec});
        if (es && !spec) scr_q.push_back('{a: a, d: ed, p: ep});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || scr_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || scr_q.size() != 0)
            chk(name, 64'(exp_q.size() + scr_q.size()), 64'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid",   64'(out_valid),   64'h0);
        chk("rst_in_ready",    64'(in_ready),    64'h1);
        chk("rst_scrub_valid", 64'(scrub_valid), 64'h0);
        chk("rst_sec_cnt",     64'(sec_cnt),     64'h0);
        chk("rst_ded_cnt",     64'(ded_cnt),     64'h0);
        chk("rst_out_data",    64'(out_data),    64'h0);

        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; scrub_ready = 1'b1;

        // data, parity, addr, special -> expected data, parity, sec, ded
        send(32'h0000_0000, 7'h00, 32'h000, 1'b0, 32'h0000_0000, 7'h00, 1'b0, 1'b0); // clean
        send(32'h0000_0001, 7'h00, 32'h100, 1'b0, 32'h0000_0000, 7'h00, 1'b1, 1'b0); // s=3 data[0]
        send(32'h0000_0003, 7'h00, 32'h104, 1'b0, 32'h0000_0003, 7'h00, 1'b0, 1'b1); // s=6 op=0
        send(32'h0000_0001, 7'h00, 32'h108, 1'b1, 32'h0000_0001, 7'h00, 1'b1, 1'b0); // special raw
        send(32'h0000_0000, 7'h40, 32'h200, 1'b0, 32'h0000_0000, 7'h00, 1'b1, 1'b0); // overall bit
        send(32'h0000_0000, 7'h01, 32'h204, 1'b0, 32'h0000_0000, 7'h00, 1'b1, 1'b0); // check bit 0
        send(32'h0000_0000, 7'h67, 32'h208, 1'b0, 32'h0000_0000, 7'h67, 1'b0, 1'b1); // s=39 > 38
        send(32'h0000_0001, 7'h43, 32'h20C, 1'b0, 32'h0000_0001, 7'h43, 1'b0, 1'b0); // clean
        send(32'h8000_0000, 7'h26, 32'h210, 1'b0, 32'h8000_0000, 7'h26, 1'b0, 1'b0); // clean, pos 38
        send(32'h0000_0000, 7'h26, 32'h300, 1'b0, 32'h8000_0000, 7'h26, 1'b1, 1'b0); // s=38 data[31]
        wait_drain("drain_a");
        chk("cnt_a_sec", 64'(sec_cnt), 64'd5);
        chk("cnt_a_ded", 64'(ded_cnt), 64'd2);

        // Scrub register stuck: second scrub word holds at S2, third fills S1.
        scrub_ready = 1'b0;
        send(32'h0000_0001, 7'h00, 32'h400, 1'b0, 32'h0, 7'h00, 1'b1, 1'b0);
        send(32'h0000_0001, 7'h00, 32'h404, 1'b0, 32'h0, 7'h00, 1'b1, 1'b0);
        send(32'h0000_0001, 7'h00, 32'h408, 1'b0, 32'h0, 7'h00, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("stall_in_ready",    64'(in_ready),     64'h0);
        chk("stall_out_valid",   64'(out_valid),    64'h1);
        chk("stall_scrub_valid", 64'(scrub_valid),  64'h1);
        chk("stall_scrub_addr",  64'(scrub_addr),   64'h400);
        chk("stall_pending",     64'(exp_q.size()), 64'd2);
        @(negedge clk);
        scrub_ready = 1'b1;
        wait_drain("drain_b");
        chk("cnt_sat_sec", 64'(sec_cnt), 64'd7);

        send(32'h0000_0001, 7'h00, 32'h40C, 1'b0, 32'h0, 7'h00, 1'b1, 1'b0);
        wait_drain("drain_c");
        chk("cnt_hold_sec", 64'(sec_cnt), 64'd7);

        // clr_cnt held only for the cycle in which the error word's handshake completes.
        send(32'h0000_0001, 7'h00, 32'h410, 1'b0, 32'h0, 7'h00, 1'b1, 1'b0);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        chk("clr_sec", 64'(sec_cnt), 64'd0);
        chk("clr_ded", 64'(ded_cnt), 64'd0);
        wait_drain("drain_d");
        chk("clr_sec_after", 64'(sec_cnt), 64'd0);

        send(32'h0000_0003, 7'h00, 32'h500, 1'b0, 32'h0000_0003, 7'h00, 1'b0, 1'b1);
        send(32'h0000_0001, 7'h00, 32'h504, 1'b0, 32'h0000_0000, 7'h00, 1'b1, 1'b0);
        wait_drain("drain_e");
        chk("cnt_e_sec", 64'(sec_cnt), 64'd1);
        chk("cnt_e_ded", 64'(ded_cnt), 64'd1);

        // Reset with a scrub pending, a word held in S2 and another in S1.
        scrub_ready = 1'b0;
        send(32'h0000_0001, 7'h00, 32'h600, 1'b0, 32'h0, 7'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        send(32'h0000_0001, 7'h43, 32'h604, 1'b0, 32'h0000_0001, 7'h43, 1'b0, 1'b0);
        send(32'h0000_0003, 7'h00, 32'h608, 1'b0, 32'h0000_0003, 7'h00, 1'b0, 1'b1);
        #1;
        chk("pre_rst_out_valid",   64'(out_valid),   64'h1);
        chk("pre_rst_scrub_valid", 64'(scrub_valid), 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        scr_q.delete();
        #1;
        chk("mid_rst_out_valid",   64'(out_valid),   64'h0);
        chk("mid_rst_in_ready",    64'(in_ready),    64'h1);
        chk("mid_rst_scrub_valid", 64'(scrub_valid), 64'h0);
        chk("mid_rst_sec_cnt",     64'(sec_cnt),     64'h0);
        chk("mid_rst_out_data",    64'(out_data),    64'h0);
        chk("mid_rst_scrub_addr",  64'(scrub_addr),  64'h0);

        @(negedge clk);
        out_ready = 1'b1; scrub_ready = 1'b1;
        send(32'h0000_0001, 7'h00, 32'h700, 1'b0, 32'h0000_0000, 7'h00, 1'b1, 1'b0);
        wait_drain("drain_f");
        chk("post_rst_sec_cnt", 64'(sec_cnt), 64'd1);
        chk("post_rst_ded_cnt", 64'(ded_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
